// File: rtl/div_report_tx.sv
// Divisor report transmitter: queues divisor bytes in a small FIFO and hands
// each one to the UART, I2C or SPI transmitter selected when the transfer begins.
module div_report_tx #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic [1:0]               con_bit_i,
    input  logic [7:0]               div_data_i,
    input  logic                     div_en_i,
    input  logic                     uart_busy_i,
    input  logic                     i2c_busy_i,
    input  logic                     spi_busy_i,
    input  logic                     uart_done_i,
    input  logic                     i2c_done_i,
    input  logic                     spi_done_i,
    output logic [7:0]               tx_data_o,
    output logic                     uart_start_o,
    output logic                     i2c_start_o,
    output logic                     spi_start_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     drop_o,
    output logic                     err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [1:0]  CH_UART = 2'b11;
    localparam logic [1:0]  CH_I2C  = 2'b10;
    localparam logic [1:0]  CH_SPI  = 2'b00;
    localparam logic [1:0]  CH_NONE = 2'b01;

    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RDY  = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            drop_q, drop_d;

    logic            sel_busy;
    logic            sel_done;
    logic            full;
    logic            push;
    logic            pop;
    logic            err;
    logic            start;

    // Only the channel latched on leaving IDLE is ever observed.
    always_comb begin
        sel_busy = 1'b1;
        sel_done = 1'b0;
        case (ch_q)
            CH_UART: begin
                sel_busy = uart_busy_i;
                sel_done = uart_done_i;
            end
            CH_I2C: begin
                sel_busy = i2c_busy_i;
                sel_done = i2c_done_i;
            end
            CH_SPI: begin
                sel_busy = spi_busy_i;
                sel_done = spi_done_i;
            end
            default: begin
                sel_busy = 1'b1;
                sel_done = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0 && con_bit_i != CH_NONE) begin
                    ch_d    = con_bit_i;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (!sel_busy) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done wins over a timeout landing on the same cycle
                if (sel_done) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    pop     = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A full FIFO still accepts a write when the head leaves on the same edge.
    always_comb begin
        full     = (level_q == LVL_FULL);
        push     = div_en_i && (!full || pop);
        drop_d   = div_en_i && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = div_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= CH_NONE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            mem_q     <= mem_d;
        end
    end

    assign start        = (state_q == START);
    assign uart_start_o = start && (ch_q == CH_UART);
    assign i2c_start_o  = start && (ch_q == CH_I2C);
    assign spi_start_o  = start && (ch_q == CH_SPI);
    assign tx_data_o    = tx_data_q;
    assign fifo_level_o = level_q;
    assign drop_o       = drop_q;
    assign err_o        = err;

endmodule

// File: tb/tb_div_report_tx.sv
// Scoreboard bench for div_report_tx: expected {channel, byte} pairs are queued
// as bytes are written and matched against each start pulse.
module tb_div_report_tx;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 20;

    logic        clk_i;
    logic        rst_n;
    logic [1:0]  con_bit_i;
    logic [7:0]  div_data_i;
    logic        div_en_i;
    logic        uart_busy_i, i2c_busy_i, spi_busy_i;
    logic        uart_done_i, i2c_done_i, spi_done_i;
    logic [7:0]  tx_data_o;
    logic        uart_start_o, i2c_start_o, spi_start_o;
    logic [$clog2(DEPTH):0] fifo_level_o;
    logic        drop_o;
    logic        err_o;

    div_report_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .con_bit_i    (con_bit_i),
        .div_data_i   (div_data_i),
        .div_en_i     (div_en_i),
        .uart_busy_i  (uart_busy_i),
        .i2c_busy_i   (i2c_busy_i),
        .spi_busy_i   (spi_busy_i),
        .uart_done_i  (uart_done_i),
        .i2c_done_i   (i2c_done_i),
        .spi_done_i   (spi_done_i),
        .tx_data_o    (tx_data_o),
        .uart_start_o (uart_start_o),
        .i2c_start_o  (i2c_start_o),
        .spi_start_o  (spi_start_o),
        .fifo_level_o (fifo_level_o),
        .drop_o       (drop_o),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [9:0] exp_q[$];
    int start_seen = 0;
    int err_cnt    = 0;
    int drop_cnt   = 0;
    int last_start_cyc = 0;
    int err_cyc    = 0;

    always @(negedge clk_i) begin : mon
        int         ns;
        logic [1:0] ch;
        logic [9:0] e;
        if (rst_n) begin
            ns = int'(uart_start_o) + int'(i2c_start_o) + int'(spi_start_o);
            if (ns != 0) begin
                check_eq("start_onehot", ns, 1);
                ch = uart_start_o ? 2'b11 : (i2c_start_o ? 2'b10 : 2'b00);
                start_seen++;
                last_start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("sb_nonempty", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("start_chan", {30'd0, ch}, {30'd0, e[9:8]});
                    check_eq("start_data", {24'd0, tx_data_o}, {24'd0, e[7:0]});
                end
            end
            if (err_o) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (drop_o) drop_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] d, output int c0);
        @(posedge clk_i);
        #1;
        div_data_i = d;
        div_en_i   = 1'b1;
        @(posedge clk_i);
        #1;
        c0       = cyc;
        div_en_i = 1'b0;
    endtask

    task automatic wait_start(input int s0, input string tag);
        for (int i = 0; i < 200 && start_seen == s0; i++) begin
            @(negedge clk_i);
            #1;
        end
        check_eq(tag, start_seen, s0 + 1);
    endtask

    task automatic pulse_done(input logic [1:0] ch);
        @(posedge clk_i);
        #1;
        uart_done_i = (ch == 2'b11);
        i2c_done_i  = (ch == 2'b10);
        spi_done_i  = (ch == 2'b00);
        @(posedge clk_i);
        #1;
        uart_done_i = 1'b0;
        i2c_done_i  = 1'b0;
        spi_done_i  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_level"}, 32'(fifo_level_o), 0);
        check_eq({tag, "_txdata"}, {24'd0, tx_data_o}, 0);
        check_eq({tag, "_starts"}, {29'd0, uart_start_o, i2c_start_o, spi_start_o}, 0);
        check_eq({tag, "_drop_err"}, {30'd0, drop_o, err_o}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c0, s0, s1, s, e0, d0;
        rst_n       = 1'b1;
        con_bit_i   = 2'b01;
        div_data_i  = '0;
        div_en_i    = 1'b0;
        uart_busy_i = 1'b0;
        i2c_busy_i  = 1'b0;
        spi_busy_i  = 1'b0;
        uart_done_i = 1'b0;
        i2c_done_i  = 1'b0;
        spi_done_i  = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_init");
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // UART single byte, latency and hold of tx_data
        con_bit_i = 2'b11;
        s0 = start_seen;
        exp_q.push_back({2'b11, 8'h2A});
        write_byte(8'h2A, c0);
        wait_start(s0, "uart_start");
        check_eq("uart_latency", last_start_cyc - c0, 2);
        check_eq("uart_level_busy", 32'(fifo_level_o), 1);
        pulse_done(2'b11);
        tick(1);
        check_eq("uart_level_done", 32'(fifo_level_o), 0);
        tick(3);
        check_eq("uart_no_repeat", start_seen, s0 + 1);
        check_eq("tx_hold", {24'd0, tx_data_o}, 32'h2A);

        // SPI overflow: fifth write dropped, four bytes drained in order
        con_bit_i  = 2'b00;
        spi_busy_i = 1'b1;
        d0 = drop_cnt;
        s0 = start_seen;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back({2'b00, 8'(i)});
            write_byte(8'(i), c0);
        end
        tick(2);
        check_eq("ovf_level", 32'(fifo_level_o), DEPTH);
        check_eq("ovf_drop", drop_cnt - d0, 1);
        check_eq("ovf_held_busy", start_seen, s0);
        spi_busy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_start(s0 + k, "ovf_start");
            pulse_done(2'b00);
        end
        tick(2);
        check_eq("ovf_level_end", 32'(fifo_level_o), 0);

        // I2C timeout
        con_bit_i = 2'b10;
        s0 = start_seen;
        e0 = err_cnt;
        exp_q.push_back({2'b10, 8'h10});
        write_byte(8'h10, c0);
        wait_start(s0, "to_start");
        s = last_start_cyc;
        for (int i = 0; i < int'(TIMEOUT) + 20 && err_cnt == e0; i++) begin
            @(negedge clk_i);
            #1;
        end
        check_eq("to_err_count", err_cnt - e0, 1);
        check_eq("to_err_cycle", err_cyc - s, TIMEOUT);
        tick(3);
        check_eq("to_level", 32'(fifo_level_o), 0);
        check_eq("to_err_single", err_cnt - e0, 1);
        check_eq("to_no_restart", start_seen, s0 + 1);

        // done on the timeout cycle wins, no err
        s0 = start_seen;
        e0 = err_cnt;
        exp_q.push_back({2'b10, 8'h11});
        write_byte(8'h11, c0);
        wait_start(s0, "tie_start");
        s = last_start_cyc;
        while (cyc < s + int'(TIMEOUT)) begin
            @(posedge clk_i);
            #1;
        end
        i2c_done_i = 1'b1;
        @(posedge clk_i);
        #1;
        i2c_done_i = 1'b0;
        tick(3);
        check_eq("tie_no_err", err_cnt, e0);
        check_eq("tie_level", 32'(fifo_level_o), 0);

        // channel switch mid-transfer; foreign done ignored
        con_bit_i = 2'b11;
        s0 = start_seen;
        exp_q.push_back({2'b11, 8'hA1});
        exp_q.push_back({2'b00, 8'hA2});
        write_byte(8'hA1, c0);
        write_byte(8'hA2, c0);
        wait_start(s0, "sw_uart_start");
        con_bit_i = 2'b00;
        pulse_done(2'b00);
        tick(2);
        check_eq("sw_spi_done_ignored", 32'(fifo_level_o), 2);
        check_eq("sw_no_extra_start", start_seen, s0 + 1);
        pulse_done(2'b11);
        wait_start(s0 + 1, "sw_spi_start");
        pulse_done(2'b00);
        tick(2);
        check_eq("sw_level_end", 32'(fifo_level_o), 0);

        // channel none holds the byte
        con_bit_i = 2'b01;
        s0 = start_seen;
        exp_q.push_back({2'b10, 8'h7F});
        write_byte(8'h7F, c0);
        tick(10);
        check_eq("none_no_start", start_seen, s0);
        check_eq("none_level", 32'(fifo_level_o), 1);
        con_bit_i = 2'b10;
        wait_start(s0, "none_i2c_start");
        pulse_done(2'b10);
        tick(2);
        check_eq("none_level_end", 32'(fifo_level_o), 0);

        // reset in WAIT_DONE with three queued
        con_bit_i   = 2'b11;
        uart_busy_i = 1'b1;
        s0 = start_seen;
        exp_q.push_back({2'b11, 8'hB1});
        write_byte(8'hB1, c0);
        write_byte(8'hB2, c0);
        write_byte(8'hB3, c0);
        tick(1);
        check_eq("rst_level_pre", 32'(fifo_level_o), 3);
        uart_busy_i = 1'b0;
        wait_start(s0, "rst_start");
        @(posedge clk_i);
        #1;
        rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid");
        tick(2);
        rst_n = 1'b1;
        exp_q.delete();
        s1 = start_seen;
        tick(20);
        check_eq("rst_no_start", start_seen, s1);
        check_eq("rst_level_post", 32'(fifo_level_o), 0);

        check_eq("sb_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_report_tx.md
DIV_REPORT_TX -- requirements
Module: div_report_tx

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 4: FIFO depth in bytes; power of two, minimum 2.
REQ-002 The block SHALL have a parameter TIMEOUT, default 1024: maximum clk_i cycles spent in WAIT_DONE; range 2..65535.
REQ-003 The block SHALL have the port clk_i  in  1  clock; all logic is rising-edge.
REQ-004 The block SHALL have the port rst_n  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have the port con_bit_i  in  2  channel select: 2'b11 UART, 2'b10 I2C, 2'b00 SPI, 2'b01 none.
REQ-006 The block SHALL have the port div_data_i  in  8  divisor byte to report.
REQ-007 The block SHALL have the port div_en_i  in  1  single-cycle write strobe for div_data_i.
REQ-008 The block SHALL have the ports uart_busy_i, i2c_busy_i, spi_busy_i  in  1 each  transmitter busy.
REQ-009 The block SHALL have the ports uart_done_i, i2c_done_i, spi_done_i  in  1 each  single-cycle transmit-complete pulse.
REQ-010 The block SHALL have the port tx_data_o  out  8  byte presented to all transmitters.
REQ-011 The block SHALL have the ports uart_start_o, i2c_start_o, spi_start_o  out  1 each  single-cycle transmit request.
REQ-012 The block SHALL have the port fifo_level_o  out  clog2(DEPTH)+1  number of queued bytes.
REQ-013 The block SHALL have the port drop_o  out  1  single-cycle pulse when a write is lost to overflow.
REQ-014 The block SHALL have the port err_o  out  1  single-cycle pulse when a transfer times out.

Function
REQ-015 The FIFO SHALL write div_data_i on a clock edge where div_en_i=1 and the FIFO is not full, or is full and a pop occurs on the same edge.
REQ-016 A div_en_i write to a full FIFO with no same-edge pop SHALL be discarded, and drop_o SHALL pulse high for one cycle; FIFO contents SHALL be unchanged.
REQ-017 The read and write pointers SHALL wrap modulo DEPTH; fifo_level_o SHALL equal the writes minus the pops, limited to 0..DEPTH.
REQ-018 The FSM SHALL have four states: IDLE, WAIT_RDY, START, WAIT_DONE.
REQ-019 In IDLE, with fifo_level_o>0 and con_bit_i != 2'b01, the FSM SHALL latch con_bit_i as the active channel and move to WAIT_RDY; otherwise it SHALL stay in IDLE.
REQ-020 In WAIT_RDY, the FSM SHALL move to START when the latched channel's busy_i=0; otherwise it SHALL stay in WAIT_RDY with no timeout.
REQ-021 In START, the FSM SHALL assert only the latched channel's start_o for exactly one cycle, with tx_data_o = FIFO head; it SHALL then move to WAIT_DONE and clear the timeout counter.
REQ-022 tx_data_o SHALL hold the last transmitted byte until the next START.
REQ-023 In WAIT_DONE, the latched channel's done_i SHALL pop the FIFO head and return the FSM to IDLE.
REQ-024 In WAIT_DONE, after TIMEOUT cycles with no done_i, the FSM SHALL pop the head, pulse err_o for one cycle, and return to IDLE.
REQ-025 If done_i and the timeout coincide, done_i SHALL take precedence and err_o SHALL stay 0.
REQ-026 done_i or busy_i from a non-latched channel SHALL be ignored; done_i outside WAIT_DONE SHALL be ignored.
REQ-027 A change of con_bit_i after IDLE SHALL NOT affect the transfer in progress; it SHALL apply only to the next IDLE exit.
REQ-028 With con_bit_i=2'b01, queued bytes SHALL be held, not discarded, and writes SHALL continue to be accepted.
REQ-029 Latency: div_en_i sampled on edge E0, with an empty FIFO, IDLE state, and busy_i=0: start_o SHALL be high in the cycle after edge E0+2.

Reset
REQ-030 While rst_n=0, the block SHALL force: FSM=IDLE, FIFO empty, pointers=0, fifo_level_o=0, tx_data_o=8'h00, all start_o=0, drop_o=0, err_o=0, timeout counter=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer and discard all queued bytes; no start_o SHALL follow release without a new div_en_i.

Verification
REQ-032 Scenario: con_bit_i=11, div_data_i=8'h2A with a div_en_i pulse, busy low -> uart_start_o pulses once, 3rd cycle, tx_data_o=8'h2A; uart_done_i -> fifo_level_o returns to 0; i2c_start_o and spi_start_o stay 0.
REQ-033 Scenario: con_bit_i=00, spi_busy_i=1, 5 writes 8'h01..8'h05 with DEPTH=4 -> fifo_level_o=4, drop_o pulses once; release busy and answer each done -> bytes 01,02,03,04 sent in order.
REQ-034 Scenario: con_bit_i=10, write 8'h10, never pulse i2c_done_i -> err_o pulses exactly TIMEOUT cycles after i2c_start_o, fifo_level_o=0, FSM back in IDLE.
REQ-035 Scenario: start a UART transfer, switch con_bit_i to 00 in WAIT_DONE, pulse spi_done_i then uart_done_i -> only uart_done_i completes the transfer; the next byte goes to SPI.
REQ-036 Scenario: con_bit_i=01, write 8'h7F -> no start_o, fifo_level_o=1; set con_bit_i=10 -> i2c_start_o with tx_data_o=8'h7F.
REQ-037 Scenario: assert rst_n=0 in WAIT_DONE with 3 bytes queued -> all outputs at reset values; after release, no start_o for 20 cycles.
